// File: rtl/joypad_pkg.sv
`default_nettype none
// ============================================================================
// Module   : joypad_pkg
// Brief    : Shared constants for the joypad serial shifter: button bit
//            positions, chain lengths and the Four Score signature byte.
// Revision : 1.0
// ============================================================================
package joypad_pkg;

  // Button bit positions within an 8-bit pad word (1 = pressed)
  localparam int unsigned BTN_A      = 0;
  localparam int unsigned BTN_B      = 1;
  localparam int unsigned BTN_SELECT = 2;
  localparam int unsigned BTN_START  = 3;
  localparam int unsigned BTN_UP     = 4;
  localparam int unsigned BTN_DOWN   = 5;
  localparam int unsigned BTN_LEFT   = 6;
  localparam int unsigned BTN_RIGHT  = 7;

  // Chain lengths: single pad, and pad A + pad B + signature
  localparam int unsigned N_STD = 8;
  localparam int unsigned N_FS  = 24;

  // Shift count width; wide enough for N_FS with headroom
  localparam int unsigned CNT_W = 5;

  // Signature byte that follows both pads on a Four Score adapter
  localparam logic [7:0] SIG_DEFAULT = 8'h08;

endpackage
`default_nettype wire

// File: rtl/joypad_edge.sv
`default_nettype none
// ============================================================================
// Module   : joypad_edge
// Brief    : Registered rising-edge detector for the active-low CPU read
//            enable. rd_end pulses on the clock where nRDP is 1 and was 0
//            on the previous clock, i.e. when a read cycle finishes.
// Revision : 1.0
// ============================================================================
module joypad_edge (
  input  logic CLK,
  input  logic RES,
  input  logic nRDP,
  output logic rd_end
);

  logic nrdp_q;
  logic nrdp_d;

  // Next value of the delayed read enable is simply the current sample
  always_comb begin
    nrdp_d = nRDP;
  end

  // Delay register; resets to idle-high so reset never fakes a read end
  always_ff @(posedge CLK) begin
    if (RES) begin
      nrdp_q <= 1'b1;
    end else begin
      nrdp_q <= nrdp_d;
    end
  end

  assign rd_end = nRDP & ~nrdp_q;

endmodule
`default_nettype wire

// File: rtl/joypad_shifter.sv
`default_nettype none
// ============================================================================
// Module   : joypad_shifter
// Brief    : Parallel-load / serial-out controller shift register. strobe=1
//            loads the buttons; each completed CPU read shifts one bit out,
//            LSB first, filling with 1. After N bits ser_d reads 1 and done
//            is high until the next load.
//            Optional macro JOYPAD_FOUR_SCORE_EN extends the chain to 24
//            bits: btn_a, btn_b, then the SIG byte.
// Revision : 1.0
// ============================================================================
module joypad_shifter
  import joypad_pkg::*;
#(
  parameter logic [7:0] SIG = SIG_DEFAULT
) (
  input  logic       CLK,
  input  logic       RES,
  input  logic       strobe,
  input  logic       nRDP,
  input  logic [7:0] btn_a,
  input  logic [7:0] btn_b,
  output logic       ser_d,
  output logic       done
);

`ifdef JOYPAD_FOUR_SCORE_EN
  localparam int unsigned N = N_FS;
`else
  localparam int unsigned N = N_STD;
`endif

  localparam logic [CNT_W-1:0] N_CNT = CNT_W'(N);

  logic [N-1:0]     load_vec;
  logic [N-1:0]     shreg_q;
  logic [N-1:0]     shreg_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             rd_end;
  logic             full;

`ifdef JOYPAD_FOUR_SCORE_EN
  assign load_vec = {SIG, btn_b, btn_a};
`else
  // Second pad and signature only exist on the Four Score chain
  logic unused_fs;
  assign load_vec  = btn_a;
  assign unused_fs = ^{btn_b, SIG};
`endif

  joypad_edge u_edge (
    .CLK    (CLK),
    .RES    (RES),
    .nRDP   (nRDP),
    .rd_end (rd_end)
  );

  assign full = (cnt_q == N_CNT);

  // Load has priority over a read end; shifting stops once N bits are out
  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (strobe) begin
      shreg_d = load_vec;
      cnt_d   = '0;
    end else if (rd_end && !full) begin
      shreg_d = {1'b1, shreg_q[N-1:1]};
      cnt_d   = cnt_q + CNT_W'(1);
    end
  end

  // State registers; reset discards any partially read chain
  always_ff @(posedge CLK) begin
    if (RES) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ser_d = full ? 1'b1 : shreg_q[0];
  assign done  = full;

endmodule
`default_nettype wire

// File: tb/tb_joypad_shifter.sv
`default_nettype none
// ============================================================================
// Module   : tb_joypad_shifter
// Brief    : Randomized scoreboard bench for joypad_shifter. The stimulus
//            side keeps an abstract model (loaded bit vector + number of
//            completed reads) and queues the expected ser_d/done for every
//            cycle the CPU reads or the bench probes; a monitor pops and
//            compares on the falling clock edge.
// Revision : 1.0
// ============================================================================
module tb_joypad_shifter;

`ifdef JOYPAD_FOUR_SCORE_EN
  localparam int N = 24;
`else
  localparam int N = 8;
`endif
  localparam logic [7:0] TB_SIG = 8'h08;

  logic       CLK = 1'b0;
  logic       RES = 1'b1;
  logic       strobe = 1'b0;
  logic       nRDP = 1'b1;
  logic [7:0] btn_a = 8'h00;
  logic [7:0] btn_b = 8'h00;
  logic       ser_d;
  logic       done;
  logic       probe = 1'b0;

  typedef struct {
    logic  s;
    logic  d;
    string tag;
  } exp_t;

  exp_t sb_q[$];
  int   compared   = 0;
  int   mismatched = 0;

  // Abstract model: the bits loaded and how many reads have completed
  logic [N-1:0] m_vec = '0;
  int           m_cnt = 0;

  joypad_shifter #(.SIG(TB_SIG)) dut (
    .CLK    (CLK),
    .RES    (RES),
    .strobe (strobe),
    .nRDP   (nRDP),
    .btn_a  (btn_a),
    .btn_b  (btn_b),
    .ser_d  (ser_d),
    .done   (done)
  );

  always #5 CLK = ~CLK;

  function automatic logic [N-1:0] chain(input logic [7:0] a, input logic [7:0] b);
`ifdef JOYPAD_FOUR_SCORE_EN
    return {TB_SIG, b, a};
`else
    return N'(a) | N'(b & 8'h00);
`endif
  endfunction

  function automatic void push_exp(input string tag);
    exp_t e;
    e.s   = (m_cnt < N) ? m_vec[m_cnt] : 1'b1;
    e.d   = (m_cnt == N);
    e.tag = tag;
    sb_q.push_back(e);
  endfunction

  // Monitor: data is presented while the CPU read is active, or on probes
  always @(negedge CLK) begin
    if (!nRDP || probe) begin
      if (sb_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL sb_underflow: DUT presented ser_d=%b done=%b with nothing expected", ser_d, done);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        compared++;
        if (ser_d !== e.s || done !== e.d) begin
          mismatched++;
          $display("FAIL %s: got ser_d=%b done=%b, expected ser_d=%b done=%b (t=%0t)",
                   e.tag, ser_d, done, e.s, e.d, $time);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic probe_now(input string tag);
    probe = 1'b1;
    push_exp(tag);
    cyc();
    probe = 1'b0;
  endtask

  task automatic do_reset();
    RES = 1'b1;
    nRDP = 1'b1;
    strobe = 1'b0;
    cyc();
    m_vec = '0;
    m_cnt = 0;
    probe_now("reset_1");
    probe_now("reset_2");
    RES = 1'b0;
    probe_now("post_reset");
  endtask

  task automatic do_load(input logic [7:0] a, input logic [7:0] b, input bit hold2);
    strobe = 1'b1;
    btn_a = a;
    btn_b = b;
    cyc();
    m_vec = chain(a, b);
    m_cnt = 0;
    if (hold2) begin
      // Buttons change while latched: picked up on the next clock
      btn_a = ~a;
      btn_b = ~b;
      probe_now("load_track_old");
      m_vec = chain(~a, ~b);
    end
    strobe = 1'b0;
    btn_a = 8'($urandom);
    btn_b = 8'($urandom);
    probe_now("load");
  endtask

  task automatic do_read(input int low_len, input string tag);
    nRDP = 1'b0;
    repeat (low_len) begin
      push_exp(tag);
      cyc();
    end
    nRDP = 1'b1;
    cyc();
    if (m_cnt < N) m_cnt++;
  endtask

  // Read ends on the same clock as a latch: the load wins
  task automatic do_simul(input logic [7:0] a, input logic [7:0] b);
    nRDP = 1'b0;
    push_exp("simul_pre");
    cyc();
    nRDP = 1'b1;
    strobe = 1'b1;
    btn_a = a;
    btn_b = b;
    cyc();
    m_vec = chain(a, b);
    m_cnt = 0;
    strobe = 1'b0;
    probe_now("simul");
  endtask

  // Reset on the same clock as a read end: reset wins
  task automatic do_midreset();
    nRDP = 1'b0;
    push_exp("midreset_pre");
    cyc();
    nRDP = 1'b1;
    RES = 1'b1;
    cyc();
    m_vec = '0;
    m_cnt = 0;
    RES = 1'b0;
    probe_now("midreset");
  endtask

  initial begin
    do_reset();

    // Directed: btn_a = A5, eight reads then overrun
    do_load(8'hA5, 8'h00, 1'b0);
    for (int i = 0; i < N; i++) do_read(1 + (i % 2), "a5_read");
    probe_now("a5_done");
    for (int i = 0; i < 3; i++) do_read(1, "overrun");
    probe_now("overrun_done");

    // Directed: simultaneous load/read end, then reset after 3 reads
    do_simul(8'h3C, 8'hC3);
    do_load(8'h5A, 8'h11, 1'b0);
    for (int i = 0; i < 3; i++) do_read(1, "pre_mid");
    do_midreset();
    do_load(8'h5A, 8'h11, 1'b0);
    for (int i = 0; i < N; i++) do_read(1, "replay");
    probe_now("replay_done");

`ifdef JOYPAD_FOUR_SCORE_EN
    do_load(8'h01, 8'h80, 1'b0);
    for (int i = 0; i < N; i++) do_read(1, "fs_read");
    probe_now("fs_done");
`endif

    do_load(8'hF0, 8'h0F, 1'b1);
    do_read(2, "tracked");

    // Randomized operation mix
    for (int k = 0; k < 150; k++) begin
      int op;
      op = int'($urandom_range(0, 11));
      if (op == 0)      do_load(8'($urandom), 8'($urandom), 1'($urandom));
      else if (op == 1) do_simul(8'($urandom), 8'($urandom));
      else if (op == 2) do_midreset();
      else if (op == 3) do_reset();
      else if (op == 4) probe_now("rand_probe");
      else              do_read(int'($urandom_range(1, 3)), "rand_read");
    end

    probe_now("final");
    cyc();
    compared++;
    if (sb_q.size() != 0) begin
      mismatched++;
      $display("FAIL sb_drain: %0d expected entries left, required 0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/joypad_shifter.md
JOYPAD_SHIFTER -- requirements
Module: joypad_shifter

Interface
REQ-001 Parameter: SIG, 8'h08, Four Score signature byte shifted out LSB first after both pads' buttons; used only with JOYPAD_FOUR_SCORE_EN.
REQ-002 Port: CLK  input  1  single system clock; all state changes on rising edge.
REQ-003 Port: RES  input  1  reset, synchronous, active-high.
REQ-004 Port: strobe  input  1  controller latch level (OUT0), synchronous to CLK; 1 = parallel load.
REQ-005 Port: nRDP  input  1  CPU port read enable, active-low, synchronous to CLK.
REQ-006 Port: btn_a  input  8  pad A buttons, 1 = pressed; bit0 A, 1 B, 2 Select, 3 Start, 4 Up, 5 Down, 6 Left, 7 Right.
REQ-007 Port: btn_b  input  8  pad B buttons, same encoding; ignored without JOYPAD_FOUR_SCORE_EN.
REQ-008 Port: ser_d  output  1  serial data bit presented to the CPU data bus, 1 = pressed.
REQ-009 Port: done  output  1  1 when all defined bits have been shifted out.

Function
REQ-010 Chain length N SHALL be 8 (btn_a) without the macro and 24 (btn_a, btn_b, SIG) with it.
- REQ-011 ser_d SHALL equal bit 0 of the internal shift register, or 1 when the shift count has reached N.
- REQ-012 While strobe=1, each CLK SHALL reload the shift register from the inputs and clear the shift count to 0.
  - Buttons changing during strobe are tracked with one cycle latency.
- REQ-013 A read-end event SHALL be defined as nRDP sampled 0 on the previous CLK and 1 on the current CLK.
  - Detection uses a registered copy of nRDP.
- REQ-014 On a read-end event with strobe=0, the shift register SHALL shift right one place, filling the MSB with 1.
  - The shift count SHALL increment, saturating at N.
- REQ-015 ser_d SHALL change only on the CLK after a read-end event or a load, never during nRDP=0.
- REQ-016 A read-end event coincident with strobe=1 SHALL be ignored; the load wins.
- REQ-017 Once the count equals N, further read-end events SHALL leave ser_d=1 and done=1.
  - No wrap-around occurs.
- REQ-018 done SHALL be 1 exactly when the count equals N.
- REQ-019 Repeated nRDP=0 without a rising edge SHALL shift at most once.
- REQ-020 Shift count width SHALL be 5 bits; values above N are unreachable.

Reset
REQ-021 RES=1 at a CLK edge SHALL clear the shift register and the shift count to 0 and set the registered nRDP to 1.
- REQ-022 During and directly after reset: ser_d=0, done=0.
- REQ-023 RES SHALL override strobe and read-end events in the same cycle.
  - Reset mid-sequence discards the remaining bits.

Configuration
REQ-024 Macro JOYPAD_FOUR_SCORE_EN defined: 24-bit chain.
  - Load order, LSB first: btn_a[7:0], btn_b[7:0], SIG[7:0].
  - done asserts after 24 reads.
- REQ-025 Macro undefined: 8-bit chain of btn_a only; btn_b and SIG unused; done asserts after 8 reads.

Structure
REQ-026 Package joypad_pkg SHALL hold: button bit index constants, the N_STD=8 and N_FS=24 length constants, and the default signature 8'h08.
- REQ-027 One sub-module joypad_edge SHALL implement the registered nRDP rising-edge detector with synchronous RES.

Verification
REQ-028 Reset: RES=1 for 2 cycles -> ser_d=0, done=0; registered nRDP=1.
- REQ-029 Load/read: btn_a=8'hA5, strobe 1->0, 8 nRDP low/high pulses -> ser_d before each read-end = 1,0,1,0,0,1,0,1; then done=1, ser_d=1.
- REQ-030 Overrun: 3 further pulses after REQ-029 -> ser_d stays 1, done stays 1, count stays 8.
- REQ-031 Simultaneous: read-end on the same CLK as strobe=1 -> count 0, ser_d = btn_a[0], no shift.
- REQ-032 Reset mid-operation: RES=1 after 3 reads -> ser_d=0, done=0; new strobe reloads and replays from bit 0.
- REQ-033 With JOYPAD_FOUR_SCORE_EN: btn_a=8'h01, btn_b=8'h80, SIG=8'h08 -> reads 1 and 16 return 1; read 20 returns 1; all others 0; done after read 24.
